// File: rtl/mips_fetch_pkg.sv
// Shared fetch-stage definitions: FSM states, PC constants and the branch
// immediate sign-extend/shift helper.
package mips_fetch_pkg;

  typedef enum logic [0:0] {
    ST_ISSUE,
    ST_WAIT
  } fetch_state_e;

  localparam logic [31:0] PC_STEP  = 32'd4;
  localparam logic [31:0] RESET_PC = 32'd0;

  // Word offset to byte offset: sign-extend 16 -> 30 bits, then append two zeros.
  function automatic logic [31:0] sign_ext_shift2(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/pc_next_logic.sv
// Next-PC priority mux: jump over taken branch over sequential.
module pc_next_logic
  import mips_fetch_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic        jump,
  input  logic [25:0] jump_target,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  output logic [31:0] next_pc
);

  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = {pc_plus4[31:28], jump_target, 2'b00};
    end else if (branch_taken) begin
      next_pc = pc_plus4 + sign_ext_shift2(branch_offset);
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and two-phase fetch sequencer (ISSUE -> WAIT) that matches the
// one-cycle registered read latency of the instruction memory.
module pc_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter int unsigned size_ward = 2,
  localparam int unsigned AW = $clog2(size_ward * 4)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          branch_taken,
  input  logic [15:0]   branch_offset,
  input  logic          jump,
  input  logic [25:0]   jump_target,
  output logic [AW-1:0] read_address,
  output logic [31:0]   pc,
  output logic [31:0]   pc_plus4,
  output logic          fetch_valid,
  output logic [31:0]   fetch_count
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  fetch_count_q, fetch_count_d;
  logic [31:0]  next_pc;
  logic         accept;

  assign pc_plus4 = pc_q + PC_STEP;

  pc_next_logic u_pc_next_logic (
    .pc_plus4      (pc_plus4),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .next_pc       (next_pc)
  );

  // Stall and redirect inputs only matter while the fetched fields are valid.
  assign accept = (state_q == ST_WAIT) && !stall;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_count_d = fetch_count_q;
    unique case (state_q)
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (accept) begin
          state_d       = ST_ISSUE;
          pc_d          = next_pc;
          fetch_count_d = fetch_count_q + 32'd1;
        end
      end
      default: state_d = ST_ISSUE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_ISSUE;
      pc_q          <= RESET_PC;
      fetch_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign pc           = pc_q;
  assign read_address = pc_q[AW-1:0];
  assign fetch_valid  = (state_q == ST_WAIT);
  assign fetch_count  = fetch_count_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed + randomized bench for pc_fetch_unit against a transaction-level model.
module tb_pc_fetch_unit;

  localparam int unsigned SizeWard = 2;
  localparam int unsigned AW       = $clog2(SizeWard * 4);
  localparam int unsigned MemBytes = SizeWard * 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          stall;
  logic          branch_taken;
  logic [15:0]   branch_offset;
  logic          jump;
  logic [25:0]   jump_target;
  logic [AW-1:0] read_address;
  logic [31:0]   pc;
  logic [31:0]   pc_plus4;
  logic          fetch_valid;
  logic [31:0]   fetch_count;

  int total = 0;
  int bad   = 0;

  // Reference model: where we are in the two-cycle fetch, current PC, accept count.
  bit          m_wait;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;

  pc_fetch_unit #(.size_ward(SizeWard)) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_target   (jump_target),
    .read_address  (read_address),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .fetch_valid   (fetch_valid),
    .fetch_count   (fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_next(input logic [31:0] cur, input bit j,
                                             input logic [25:0] jt, input bit bt,
                                             input logic [15:0] bo);
    logic [31:0] seq;
    int          woff;
    seq = cur + 32'd4;
    if (j) return (seq & 32'hF000_0000) | (32'(jt) * 32'd4);
    if (bt) begin
      woff = $signed(bo);
      return seq + 32'(woff * 4);
    end
    return seq;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ":pc"}, pc, m_pc);
    check({tag, ":ra"}, 32'(read_address), m_pc % MemBytes);
    check({tag, ":pc4"}, pc_plus4, m_pc + 32'd4);
    check({tag, ":valid"}, 32'(fetch_valid), 32'(m_wait));
    check({tag, ":count"}, fetch_count, m_cnt);
  endtask

  // One clock: model advances with the inputs present at the edge, then outputs are checked.
  task automatic cycle(input string tag);
    @(posedge clk);
    if (!m_wait) begin
      m_wait = 1'b1;
    end else if (!stall) begin
      m_pc   = model_next(m_pc, jump, jump_target, branch_taken, branch_offset);
      m_cnt  = m_cnt + 32'd1;
      m_wait = 1'b0;
    end
    #1;
    check_all(tag);
  endtask

  task automatic set_in(input bit s, input bit j, input logic [25:0] jt, input bit bt,
                        input logic [15:0] bo);
    stall = s; jump = j; jump_target = jt; branch_taken = bt; branch_offset = bo;
  endtask

  // Run with no stall/redirect until the model sits in WAIT.
  task automatic to_wait();
    set_in(1'b0, 1'b0, 26'h0, 1'b0, 16'h0);
    while (!m_wait) cycle("to_wait");
  endtask

  // In WAIT: present a redirect and accept it, landing at the next WAIT.
  task automatic take(input string tag, input bit j, input logic [25:0] jt, input bit bt,
                      input logic [15:0] bo, input logic [31:0] exp_pc);
    to_wait();
    set_in(1'b0, j, jt, bt, bo);
    cycle(tag);
    check({tag, ":target"}, pc, exp_pc);
    to_wait();
  endtask

  initial begin
    set_in(1'b0, 1'b0, 26'h0, 1'b0, 16'h0);
    reset  = 1'b1;
    m_wait = 1'b0;
    m_pc   = 32'd0;
    m_cnt  = 32'd0;
    #12;
    check_all("reset");
    reset = 1'b0;

    // Sequential fetch with address aliasing in an 8-byte memory.
    for (int i = 0; i < 8; i++) cycle("seq");
    check("seq_count4", fetch_count, 32'd4);
    check("seq_pc", pc, 32'd16);

    // Restart at PC 0, step to PC 4, then branch backward onto itself and forward.
    to_wait();
    #2 reset = 1'b1;
    #1;
    m_wait = 1'b0; m_pc = 32'd0; m_cnt = 32'd0;
    check_all("rst_mid_wait");
    @(negedge clk);
    reset = 1'b0;
    check_all("post_rst_issue");
    cycle("post_rst_wait");
    take("seq_to4", 1'b0, 26'h0, 1'b0, 16'h0, 32'h4);
    take("br_back", 1'b0, 26'h0, 1'b1, 16'hFFFF, 32'h4);
    take("br_fwd", 1'b0, 26'h0, 1'b1, 16'h0002, 32'h10);
    take("jmp_prio", 1'b1, 26'h3, 1'b1, 16'h0002, 32'hC);
    // Far backward branch wraps modulo 2^32; then jump into the 0xF region.
    take("br_wrap", 1'b0, 26'h0, 1'b1, 16'h8000, 32'hFFFE_0010);
    take("jmp_hi", 1'b1, 26'h0, 1'b0, 16'h0, 32'hF000_0000);
    take("jmp_hi3", 1'b1, 26'h3, 1'b1, 16'h0002, 32'hF000_000C);

    // Stall hold with jump toggling, then release sequentially.
    to_wait();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, i[0] == 1'b0, 26'h155, 1'b1, 16'h0010);
      cycle("stall_hold");
      check("stall_pc", pc, 32'hF000_000C);
    end
    set_in(1'b0, 1'b0, 26'h155, 1'b0, 16'h0010);
    cycle("stall_release");
    check("stall_adv", pc, 32'hF000_0010);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      set_in($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, 26'($urandom),
             $urandom_range(0, 2) == 0, 16'($urandom));
      cycle("rand");
    end

    // Counter wrap.
    to_wait();
    force dut.fetch_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.fetch_count_q;
    #1;
    m_cnt = 32'hFFFF_FFFF;
    check("cnt_preset", fetch_count, 32'hFFFF_FFFF);
    set_in(1'b0, 1'b0, 26'h0, 1'b0, 16'h0);
    cycle("cnt_wrap");
    check("cnt_zero", fetch_count, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
